unsigned_approx_mult_pipe: RTL and testbench
============================================

// Module: unsigned_approx_mult_pipe
// PURPOSE
//  Pipelined, parametrised unsigned approximate multiplier with valid/ready flow control.
//  Generalises the fixed 8x8 truncated-low-row multipliers to any WIDTH and truncation level L.
//  Per-transaction mode selects exact or approximate product; a counter tracks approximate ops.
//  Sits in the datapath wherever the multiplier library is used with a registered interface.
// PARAMETERS
//  WIDTH   8   operand width; product width is 2*WIDTH
//  L       4   number of low x rows approximated (1 <= L < WIDTH)
//  CNT_W   16  width of approximate-transaction counter
// PORTS
//  clk         in   1          clock, rising edge
//  rst_n       in   1          asynchronous active-low reset
//  in_valid    in   1          operand pair valid
//  in_ready    out  1          block accepts operands this cycle
//  x           in   WIDTH      multiplicand (rows)
//  y           in   WIDTH      multiplier (columns)
//  approx_en   in   1          1 = approximate product, 0 = exact
//  out_valid   out  1          z valid
//  out_ready   in   1          downstream accepts z
//  z           out  2*WIDTH    product
//  z_approx    out  1          approx_en that produced z
//  approx_cnt  out  CNT_W      accepted approximate transactions, saturating
// BEHAVIOUR
//  - Reset: all stage valids, out_valid, z, z_approx, approx_cnt = 0; in_ready = 1 after reset.
//  - Pipeline: S1 registers x/y/approx_en; S2 registers high product y*x[W-1:L] and low term;
//    S3 registers final sum onto z. Latency 3 cycles accept-to-out_valid with no stall.
//  - Flow: adv = !out_valid | out_ready; all stages shift together when adv; in_ready = adv.
//    Transfer on in_valid&in_ready; empty stages (valid=0) propagate bubbles. Stall holds
//    all stage data and z stable; out_valid never deasserts without out_ready.
//  - pp[i][j] = x[i] & y[j], weight 2^(i+j). Exact low term = sum over i<L of all pp[i][j].
//  - Approx low term: columns c < WIDTH-1 contribute 0. For c >= WIDTH-1, rows i<L paired
//    (2k,2k+1): if both pp exist (0<=c-i<WIDTH) contribute (a|b)<<c; if one exists, that bit
//    exact <<c; odd last row (L odd) exact. Sum of terms at most 2*WIDTH bits, no overflow.
//  - z = (y * x[W-1:L]) << L + low term (exact or approx per approx_en), width 2*WIDTH.
//  - approx_cnt increments by 1 on each accepted transfer with approx_en=1; holds at
//    2^CNT_W-1. Counting is at input acceptance, not output.
//  - Simultaneous accept and output handshake in one cycle: both occur, no bubble inserted.
//  - Reset mid-operation: in-flight transactions discarded, nothing emitted after release.
//  - x or y = 0 -> z = 0 in both modes; x[L-1:0] = 0 -> approx z equals exact z.
// STRUCTURE
//  - Package approx_mult_pkg: function pair_comp(x_low, y) returning approx low term,
//    function exact_low(x_low, y), localparam PROD_W = 2*WIDTH.
//  - One sub-module natural: approx_mult_lowterm (combinational, WIDTH/L params,
//    exact and approx low terms, approx_en select), instanced in S2.
//  - Top holds pipeline registers, flow control, counter.
// TESTING
//  - WIDTH=8,L=4: x=8'h0F,y=8'hFF,approx_en=1 -> z=16'h0900; approx_en=0 -> z=16'h0EF1.
//  - x=8'hF0,y=8'h0F both modes -> z=16'h0E10 (low rows zero, exact == approx).
//  - Back-to-back 10 inputs, out_ready=1 -> first out_valid 3 cycles after first accept,
//    then one result per cycle, in order; out_ready low 4 cycles mid-stream -> in_ready low,
//    z held stable, no loss or duplication.
//  - CNT_W=4, 20 accepted approx ops plus 5 exact -> approx_cnt = 4'hF, stays saturated.
//  - Assert rst_n low with 3 ops in flight -> out_valid=0, approx_cnt=0 immediately; no
//    stale output after release.
//  - Random x,y,mode over WIDTH=8/L=4 and WIDTH=12/L=5 vs reference model of above rules.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// ============================================================================
// approx_mult_pkg
// Shared low-term arithmetic for the approximate multiplier family.
// Revision: 1.0
// ============================================================================
`default_nettype none

package approx_mult_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int PROD_W    = 2 * DEF_WIDTH;
  // Functions work on zero-extended operands of this width so any WIDTH < MAX_W fits.
  localparam int MAX_W     = 32;
  localparam int ACC_W     = 2 * MAX_W;
  localparam int IDX_W     = 5;

  // x_low must already have every row at or above L cleared by the caller.
  function automatic logic [ACC_W-1:0] exact_low(input logic [MAX_W-1:0] x_low,
                                                 input logic [MAX_W-1:0] y);
    logic [ACC_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (x_low[i]) acc = acc + ({{MAX_W{1'b0}}, y} << i);
    end
    return acc;
  endfunction

  // Columns below width-1 are dropped; rows are OR-merged in pairs (2k, 2k+1).
  function automatic logic [ACC_W-1:0] pair_comp(input logic [MAX_W-1:0] x_low,
                                                 input logic [MAX_W-1:0] y,
                                                 input int              width,
                                                 input int              l);
    logic [ACC_W-1:0] acc;
    logic             a_ex;
    logic             b_ex;
    logic             a;
    logic             b;
    acc = '0;
    for (int c = 0; c < ACC_W; c++) begin
      for (int k = 0; k < MAX_W; k += 2) begin
        a_ex = (c >= width - 1) && (k < l) && (c - k >= 0) && (c - k < width);
        b_ex = (c >= width - 1) && (k + 1 < l) && (c - k - 1 >= 0) && (c - k - 1 < width);
        a    = a_ex && x_low[IDX_W'(k)] && y[IDX_W'(c - k)];
        b    = b_ex && x_low[IDX_W'(k + 1)] && y[IDX_W'(c - k - 1)];
        acc  = acc + ({{(ACC_W-1){1'b0}}, (a | b)} << c);
      end
    end
    return acc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/approx_mult_lowterm.sv
// ============================================================================
// approx_mult_lowterm
// Combinational low-row term (rows below L), exact or approximate per approx_en.
// Revision: 1.0
// ============================================================================
`default_nettype none

module approx_mult_lowterm
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int L     = 4
) (
  input  logic [L-1:0]       x_low,
  input  logic [WIDTH-1:0]   y,
  input  logic               approx_en,
  output logic [2*WIDTH-1:0] low
);

  localparam int LOW_W = 2 * WIDTH;

  logic [MAX_W-1:0] x_ext;
  logic [MAX_W-1:0] y_ext;
  logic [ACC_W-1:0] exact_full;
  logic [ACC_W-1:0] approx_full;
  logic [ACC_W-1:0] sel_full;
  logic             unused_hi;

  assign x_ext = {{(MAX_W-L){1'b0}}, x_low};
  assign y_ext = {{(MAX_W-WIDTH){1'b0}}, y};

  always_comb begin
    exact_full  = exact_low(x_ext, y_ext);
    approx_full = pair_comp(x_ext, y_ext, WIDTH, L);
  end

  assign sel_full  = approx_en ? approx_full : exact_full;
  assign low       = sel_full[LOW_W-1:0];
  // Both terms are bounded below 2^LOW_W, so the upper bits are always zero.
  assign unused_hi = ^sel_full[ACC_W-1:LOW_W];

endmodule

`default_nettype wire

// File: rtl/unsigned_approx_mult_pipe.sv
// ============================================================================
// unsigned_approx_mult_pipe
// Three-stage valid/ready unsigned multiplier with per-op approximate low rows.
// Revision: 1.0
// ============================================================================
`default_nettype none

module unsigned_approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int L     = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z,
  output logic               z_approx,
  output logic [CNT_W-1:0]   approx_cnt
);

  localparam int ZW = 2 * WIDTH;

  logic             adv;
  logic             accept;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_y;
  logic             s1_approx;

  logic             s2_valid;
  logic [ZW-1:0]    s2_hi;
  logic [ZW-1:0]    s2_low;
  logic             s2_approx;

  logic [ZW-1:0]    hi_prod;
  logic [ZW-1:0]    low_term;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // Upper rows x[W-1:L] are always exact; the shift restores their weight.
  assign hi_prod = ({{WIDTH{1'b0}}, s1_y} * {{(WIDTH+L){1'b0}}, s1_x[WIDTH-1:L]}) << L;

  approx_mult_lowterm #(
    .WIDTH (WIDTH),
    .L     (L)
  ) u_lowterm (
    .x_low     (s1_x[L-1:0]),
    .y         (s1_y),
    .approx_en (s1_approx),
    .low       (low_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_approx <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x      <= x;
        s1_y      <= y;
        s1_approx <= approx_en;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_hi     <= '0;
      s2_low    <= '0;
      s2_approx <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_hi     <= hi_prod;
        s2_low    <= low_term;
        s2_approx <= s1_approx;
      end
    end
  end

  // Bubbles leave z untouched so the output only changes on a real result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      z         <= '0;
      z_approx  <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        z        <= s2_hi + s2_low;
        z_approx <= s2_approx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      approx_cnt <= '0;
    end else if (accept && approx_en && (approx_cnt != {CNT_W{1'b1}})) begin
      approx_cnt <= approx_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_unsigned_approx_mult_pipe.sv
// ============================================================================
// tb_unsigned_approx_mult_pipe
// Scoreboard bench for two multiplier instances (8/4 with 4-bit counter, 12/5).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_unsigned_approx_mult_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        iv8, or8, ap8;
  logic [7:0]  x8, y8;
  logic        ir8, ov8, za8;
  logic [15:0] z8;
  logic [3:0]  cnt8;

  logic        iv12, or12, ap12;
  logic [11:0] x12, y12;
  logic        ir12, ov12, za12;
  logic [23:0] z12;
  logic [15:0] cnt12;

  unsigned_approx_mult_pipe #(.WIDTH(8), .L(4), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .x(x8), .y(y8),
    .approx_en(ap8), .out_valid(ov8), .out_ready(or8), .z(z8), .z_approx(za8),
    .approx_cnt(cnt8)
  );

  unsigned_approx_mult_pipe #(.WIDTH(12), .L(5), .CNT_W(16)) dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv12), .in_ready(ir12), .x(x12), .y(y12),
    .approx_en(ap12), .out_valid(ov12), .out_ready(or12), .z(z12), .z_approx(za12),
    .approx_cnt(cnt12)
  );

  typedef struct {
    logic [31:0] z;
    logic        a;
  } exp_t;

  exp_t        q8[$];
  exp_t        q12[$];
  int          ecnt8 = 0;
  int          ecnt12 = 0;
  logic        hold8 = 1'b0;
  logic        hold12 = 1'b0;
  logic [31:0] pz8 = '0;
  logic [31:0] pz12 = '0;
  logic        track8 = 1'b0;
  int          first_acc8 = -1;
  int          first_out8 = -1;
  int          last_out8 = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Approximate product = full product minus exact low rows plus OR-merged kept columns.
  function automatic logic [31:0] ref_z(input int w, input int l, input logic [31:0] x,
                                        input logic [31:0] y, input logic ap);
    logic [31:0] ex, lowx, acc, ba, bb;
    ex = x * y;
    if (!ap) return ex;
    lowx = x & ((32'd1 << l) - 32'd1);
    acc  = ex - lowx * y;
    for (int k = 0; k < l; k += 2) begin
      for (int c = w - 1; c <= 2 * w - 2; c++) begin
        ba = 32'd0;
        bb = 32'd0;
        if (c - k < w) ba = (x >> k) & (y >> (c - k)) & 32'd1;
        if ((k + 1 < l) && (c - k - 1 < w)) bb = (x >> (k + 1)) & (y >> (c - k - 1)) & 32'd1;
        acc = acc + ((ba | bb) << c);
      end
    end
    return acc;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q8.delete();
      ecnt8 = 0;
      hold8 = 1'b0;
    end else begin
      check("cnt8", cnt8, ecnt8);
      if (hold8) begin
        check("hold_valid8", ov8, 1);
        check("hold_z8", z8, pz8);
      end
      if (ov8 && or8) begin
        check("out8_expected", (q8.size() != 0), 1);
        if (q8.size() != 0) begin
          e = q8.pop_front();
          check("z8", z8, e.z);
          check("za8", za8, e.a);
        end
        if (track8) begin
          if (first_out8 < 0) first_out8 = cyc;
          last_out8 = cyc;
        end
      end
      if (iv8 && ir8) begin
        q8.push_back('{ref_z(8, 4, x8, y8, ap8), ap8});
        if (ap8 && ecnt8 < 15) ecnt8++;
        if (track8 && first_acc8 < 0) first_acc8 = cyc;
      end
      hold8 = ov8 && !or8;
      pz8   = z8;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q12.delete();
      ecnt12 = 0;
      hold12 = 1'b0;
    end else begin
      check("cnt12", cnt12, ecnt12);
      if (hold12) begin
        check("hold_valid12", ov12, 1);
        check("hold_z12", z12, pz12);
      end
      if (ov12 && or12) begin
        check("out12_expected", (q12.size() != 0), 1);
        if (q12.size() != 0) begin
          e = q12.pop_front();
          check("z12", z12, e.z);
          check("za12", za12, e.a);
        end
      end
      if (iv12 && ir12) begin
        q12.push_back('{ref_z(12, 5, x12, y12, ap12), ap12});
        if (ap12 && ecnt12 < 65535) ecnt12++;
      end
      hold12 = ov12 && !or12;
      pz12   = z12;
    end
  end

  task automatic send8(input logic [7:0] xv, input logic [7:0] yv, input logic av);
    int   n;
    logic acc;
    n   = 0;
    iv8 = 1'b1;
    x8  = xv;
    y8  = yv;
    ap8 = av;
    do begin
      @(negedge clk);
      acc = ir8;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    check("send8_accept", acc, 1);
    iv8 = 1'b0;
  endtask

  task automatic expect_next8(input string tag, input logic [31:0] ez);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov8 && n < 20);
    check({tag, "_seen"}, ov8, 1);
    check(tag, z8, ez);
    @(posedge clk);
    #1;
  endtask

  task automatic drain_all();
    int n;
    n    = 0;
    or8  = 1'b1;
    or12 = 1'b1;
    while ((q8.size() != 0 || q12.size() != 0) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain8", q8.size(), 0);
    check("drain12", q12.size(), 0);
  endtask

  task automatic rand8(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      iv8 = 1'($urandom_range(0, 1));
      x8  = 8'($urandom);
      y8  = 8'($urandom);
      ap8 = 1'($urandom_range(0, 1));
      or8 = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    iv8 = 1'b0;
    or8 = 1'b1;
  endtask

  task automatic rand12(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      iv12 = 1'($urandom_range(0, 1));
      x12  = 12'($urandom);
      y12  = 12'($urandom);
      ap12 = 1'($urandom_range(0, 1));
      or12 = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    iv12 = 1'b0;
    or12 = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    iv8 = 1'b0; or8 = 1'b1; ap8 = 1'b0; x8 = '0; y8 = '0;
    iv12 = 1'b0; or12 = 1'b1; ap12 = 1'b0; x12 = '0; y12 = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid8", ov8, 0);
    check("rst_z8", z8, 0);
    check("rst_za8", za8, 0);
    check("rst_cnt8", cnt8, 0);
    check("rst_in_ready8", ir8, 1);
    check("rst_out_valid12", ov12, 0);
    check("rst_cnt12", cnt12, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send8(8'h0F, 8'hFF, 1'b1); expect_next8("vec_0f_ff_apx", 32'h0900);
    send8(8'h0F, 8'hFF, 1'b0); expect_next8("vec_0f_ff_exact", 32'h0EF1);
    send8(8'hF0, 8'h0F, 1'b1); expect_next8("vec_f0_0f_apx", 32'h0E10);
    send8(8'hF0, 8'h0F, 1'b0); expect_next8("vec_f0_0f_exact", 32'h0E10);
    send8(8'h00, 8'hAB, 1'b1); expect_next8("x_zero", 32'h0);
    send8(8'hCD, 8'h00, 1'b1); expect_next8("y_zero", 32'h0);
    send8(8'hFF, 8'hFF, 1'b0); expect_next8("max_exact", 32'hFE01);

    track8 = 1'b1;
    for (int i = 0; i < 10; i++) send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    drain_all();
    track8 = 1'b0;
    check("latency", first_out8 - first_acc8, 3);
    check("stream_rate", last_out8 - first_out8, 9);

    fork
      begin
        for (int i = 0; i < 10; i++) send8(8'($urandom), 8'($urandom), 1'b1);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        or8 = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("stall_in_ready", ir8, 0);
        end
        @(posedge clk);
        #1;
        or8 = 1'b1;
      end
    join
    drain_all();

    for (int i = 0; i < 3; i++) send8(8'($urandom), 8'($urandom), 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", ov8, 0);
    check("midrst_cnt", cnt8, 0);
    check("midrst_z", z8, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_idle", ov8, 0);

    for (int i = 0; i < 10; i++) send8(8'($urandom), 8'($urandom), 1'b1);
    check("cnt_at_10", cnt8, 10);
    for (int i = 0; i < 10; i++) send8(8'($urandom), 8'($urandom), 1'b1);
    for (int i = 0; i < 5; i++) send8(8'($urandom), 8'($urandom), 1'b0);
    drain_all();
    check("cnt_saturated", cnt8, 15);
    send8(8'h33, 8'h44, 1'b1);
    drain_all();
    check("cnt_stays_sat", cnt8, 15);

    fork
      rand8(400);
      rand12(400);
    join
    drain_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
